// File: rtl/seq_multiplier.sv
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Multi-cycle shift-add multiplier (unsigned or radix-2 Booth)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     mul_q, mul_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic                 qm1_q, qm1_d;
    logic                 sgn_q, sgn_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       w_xext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mul_q   <= '0;
            x_q     <= '0;
            qm1_q   <= 1'b0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mul_q   <= mul_d;
            x_q     <= x_d;
            qm1_q   <= qm1_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        x_d     = x_q;
        qm1_d   = qm1_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;
        // One extra accumulator bit holds the unsigned carry / signed overflow
        w_xext  = sgn_q ? {x_q[WIDTH-1], x_q} : {1'b0, x_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x;
                    mul_d   = y;
                    sgn_d   = signed_mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    qm1_d   = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (!sgn_q) begin
                    if (mul_q[0]) acc_d = acc_q + w_xext;
                end else begin
                    case ({mul_q[0], qm1_q})
                        2'b01:   acc_d = acc_q + w_xext;
                        2'b10:   acc_d = acc_q - w_xext;
                        default: acc_d = acc_q;
                    endcase
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                acc_d   = {sgn_q & acc_q[WIDTH], acc_q[WIDTH:1]};
                mul_d   = {acc_q[0], mul_q[WIDTH-1:1]};
                qm1_d   = mul_q[0];
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == c_last) ? S_DONE : S_ADD;
            end
            S_DONE: begin
                p_d     = {acc_q[WIDTH-1:0], mul_q};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign p    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// Module   : tb_seq_multiplier
// Purpose  : Directed self-checking bench for seq_multiplier (WIDTH 8 and 4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  x4 = '0, y4 = '0;
    logic        busy4, done4;
    logic [7:0]  p4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .x(x8), .y(y8), .busy(busy8), .done(done8), .p(p8)
    );

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .x(x4), .y(y4), .busy(busy4), .done(done4), .p(p4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single operation on the 8-bit instance: checks busy span, latency, product, done width
    task automatic op8(input string tag, input logic sm, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp);
        int lat;
        int nb;
        @(negedge clk);
        sm8 = sm; x8 = a; y8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        nb = busy8 ? 1 : 0;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy8) nb++;
        end
        check({tag, "_lat"}, lat, 17);
        check({tag, "_busy"}, nb, 17);
        check({tag, "_p"}, {16'h0, p8}, {16'h0, exp});
        @(posedge clk); #1;
        check({tag, "_done1"}, {31'h0, done8}, 32'h0);
    endtask

    task automatic op4(input string tag, input logic sm, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] exp);
        int lat;
        @(negedge clk);
        sm4 = sm; x4 = a; y4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 9);
        check({tag, "_p"}, {24'h0, p4}, {24'h0, exp});
        @(posedge clk); #1;
        check({tag, "_done1"}, {31'h0, done4}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nd, t1, t2;

        // Reset state
        #12;
        check("rst_busy8", {31'h0, busy8}, 32'h0);
        check("rst_done8", {31'h0, done8}, 32'h0);
        check("rst_p8", {16'h0, p8}, 32'h0);
        check("rst_p4", {24'h0, p4}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        op8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s_fd_05", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        op8("u_fd_05", 1'b0, 8'hFD, 8'h05, 16'h04F1);
        op8("s_7f_80", 1'b1, 8'h7F, 8'h80, 16'hC080);
        op8("s_00_80", 1'b1, 8'h00, 8'h80, 16'h0000);

        // Start and operand churn while busy: only the first accept counts
        @(negedge clk);
        sm8 = 1'b0; x8 = 8'h12; y8 = 8'h34; start8 = 1'b1;
        @(posedge clk); #1;
        lat = 0; nd = 0;
        while (!done8 && lat < 40) begin
            sm8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom); start8 = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0;
        check("churn_lat", lat, 17);
        check("churn_p", {16'h0, p8}, 32'h03A8);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8) nd++;
        end
        check("churn_extra_done", nd, 0);

        // Back-to-back accepts with start held high
        @(negedge clk);
        sm8 = 1'b0; x8 = 8'h03; y8 = 8'h05; start8 = 1'b1;
        @(posedge clk); #1;
        nd = 0; t1 = 0; t2 = 0;
        for (int k = 1; k <= 53; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                nd++;
                t1 = t2; t2 = k;
                check("b2b_p", {16'h0, p8}, 32'h000F);
            end
        end
        start8 = 1'b0;
        check("b2b_count", nd, 3);
        check("b2b_first", t2 - 36, 17);
        check("b2b_interval", t2 - t1, 18);
        repeat (3) @(posedge clk);

        // Reset mid-operation
        @(negedge clk);
        sm8 = 1'b0; x8 = 8'h21; y8 = 8'h07; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy8}, 32'h0);
        check("arst_done", {31'h0, done8}, 32'h0);
        check("arst_p", {16'h0, p8}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) nd++;
        end
        check("arst_quiet", nd, 0);
        op8("post_rst", 1'b0, 8'h21, 8'h07, 16'h00E7);

        // WIDTH = 4 instance
        op4("w4_u_d_b", 1'b0, 4'hD, 4'hB, 8'h8F);
        op4("w4_s_8_7", 1'b1, 4'h8, 4'h7, 8'hC8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised multi-cycle shift-add multiplier with a start/busy/done handshake. Operands are WIDTH bits, selectable per operation as unsigned (add-and-shift) or two's complement (radix-2 Booth). Supersedes the fixed 4-bit unsigned multiplier. Used wherever a low-area product is acceptable at 2*WIDTH+1 cycles of latency.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  0 = unsigned operands, 1 = two's complement; latched with operands
x  input  WIDTH  multiplicand; latched on accept
y  input  WIDTH  multiplier; latched on accept
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; p is valid from the same cycle
p  output  2*WIDTH  product register; holds last result until next done

Behaviour:
- Reset (async, any state): state=IDLE, p=0, done=0, busy=0, iteration counter=0, internal accumulator and shift registers=0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, ADD, SHIFT, DONE; 2-bit encoding; unreachable encodings go to IDLE.
- IDLE: busy=0. If start=1 at an edge: latch x, y, signed_mode; clear accumulator (WIDTH+1 bits); clear counter; clear Booth bit q(-1)=0; go to ADD.
- ADD, unsigned: if multiplier LSB=1, acc += zero-extended x.
- ADD, signed: on {LSB, q(-1)}: 01 -> acc += sign-extended x; 10 -> acc -= sign-extended x; 00/11 -> acc unchanged. Go to SHIFT.
- SHIFT: shift {acc, multiplier, q(-1)} right by one. Unsigned: fill MSB with 0; acc carry is preserved in acc MSB. Signed: arithmetic shift, duplicating acc MSB. counter += 1. If counter was WIDTH-1 go to DONE, else go to ADD.
- DONE: p <= {acc[WIDTH-1:0], multiplier}, i.e. the low 2*WIDTH bits. done <= 1 for this one edge only. Go to IDLE.
- Latency: start sampled at edge E0; p and done update at edge E0 + 2*WIDTH + 1. For WIDTH=8 this is 17 cycles.
- Throughput: the earliest next accept is the edge after done is asserted, because DONE is busy and IDLE samples start one cycle later.
- start while busy=1, including the DONE cycle: ignored. It is not queued.
- Operand inputs and signed_mode may change freely after accept without affecting the result in progress.
- Width rules: full product range is representable. Unsigned max is (2^W-1)^2. Signed extreme -2^(W-1) * -2^(W-1) = 2^(2W-2) is positive and fits in 2W bits. The internal acc needs WIDTH+1 bits to hold the unsigned carry and the signed subtract overflow.
- p is not cleared on a new start; it changes only at DONE or on reset.
- done is registered and is never high for two consecutive cycles.

Test Plan:
- WIDTH=8, unsigned, x=0xFF, y=0xFF, start at E0 -> busy high E0+1..E0+17; p=0xFE01 with done=1 for exactly one cycle after E0+17.
- WIDTH=8, signed, x=0x80, y=0x80 (-128*-128) -> p=0x4000. Then x=0xFD, y=0x05 (-3*5) signed -> p=0xFFF1. Same operands unsigned (253*5) -> p=0x04F1.
- WIDTH=8, signed, x=0x7F, y=0x80 (127*-128) -> p=0xC080. Then x=0, y=0x80 -> p=0x0000, confirming the previous p is overwritten.
- Start pulses and operand changes every cycle while busy -> a single result matching the operands latched at the first accept; exactly one done per accepted start. Back-to-back starts are accepted every 18 cycles.
- Assert rst at E0+6 mid-operation -> busy, done, p return to 0 asynchronously; no done follows. A new start after rst deasserts gives a correct product.
- WIDTH=4, unsigned, x=0xD, y=0xB -> p=0x8F after 9 cycles. WIDTH=4, signed, x=0x8, y=0x7 (-8*7) -> p=0xC8.
